rom_fetch_bridge: RTL and testbench

- Backs the memory interface of the 23128 ROM controller with a shared, variable-latency memory port.
- ROM-side inputs: addr (14 b), c_out (chip enable). ROM-side output: data_out (8 b).
- Holds a 2-entry buffer (demand + sequential prefetch) so that 6502 opcode/operand fetches are normally satisfied 1 clk after the address is presented, well before the next phi0 edge.

---
 rtl/rom_bridge_pkg.sv | 24 ++
 rtl/rom_fetch_bridge_if.sv | 26 ++
 rtl/rom_line_buf.sv | 67 ++++++
 rtl/rom_fetch_bridge.sv | 155 +++++++++++++++
 tb/tb_rom_fetch_bridge.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_bridge_pkg.sv
// Shared types for the ROM fetch bridge: FSM states, buffer entry layout and
// the tag increment used for sequential prefetch.
package rom_bridge_pkg;

  localparam int ROM_AW = 14;

  typedef enum logic [1:0] {
    IDLE,
    DEMAND,
    PREFETCH
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [ROM_AW-1:0] tag;
    logic [7:0]        data;
  } rom_entry_t;

  // Sequential successor; 16383 wraps to 0.
  function automatic logic [ROM_AW-1:0] next_tag(input logic [ROM_AW-1:0] t);
    return t + ROM_AW'(1);
  endfunction

endpackage

// File: rtl/rom_fetch_bridge_if.sv
// Shared backing-memory read port: the bridge is the master, the memory
// arbiter the slave.
interface rom_fetch_bridge_if #(
  parameter int MEM_AW = 18
) ();

  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/rom_line_buf.sv
// Two-entry tag/data store with hit compare, fill-order LRU and invalidate-all.
// Entries are replaced in least-recently-filled order.
module rom_line_buf
  import rom_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              lookup_en,
  input  logic [ROM_AW-1:0] lookup_addr,
  input  logic [ROM_AW-1:0] probe_addr,
  input  logic              fill_en,
  input  logic [ROM_AW-1:0] fill_tag,
  input  logic [7:0]        fill_data,
  input  logic              inval_all,
  output logic              hit,
  output logic [7:0]        hit_data,
  output logic              probe_hit
);

  logic            mru_reg;
  logic            lru;
  logic [1:0]      match;
  logic [1:0]      probe_match;
  logic [1:0][7:0] data_w;

  assign lru = ~mru_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      rom_entry_t entry_reg;

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          entry_reg <= '0;
        end else if (inval_all) begin
          entry_reg.valid <= 1'b0;
        end else if (fill_en && (lru == 1'(gi))) begin
          entry_reg <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
        end
      end

      assign match[gi]       = lookup_en && entry_reg.valid && (entry_reg.tag == lookup_addr);
      assign probe_match[gi] = entry_reg.valid && (entry_reg.tag == probe_addr);
      assign data_w[gi]      = entry_reg.data;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mru_reg <= 1'b0;
    end else if (fill_en && !inval_all) begin
      mru_reg <= lru;
    end
  end

  // On a double hit the most recently filled entry wins.
  always_comb begin
    hit      = |match;
    hit_data = match[mru_reg] ? data_w[mru_reg] : data_w[lru];
  end

  // Only the MRU entry survives the fill that accompanies this probe, so an
  // address held in the LRU entry does not count as buffered.
  assign probe_hit = probe_match[mru_reg];

endmodule

// File: rtl/rom_fetch_bridge.sv
// Serves 23128 ROM reads from a shared variable-latency memory port through a
// 2-entry demand/prefetch buffer. AW must equal ROM_AW (buffer tag width).
module rom_fetch_bridge
  import rom_bridge_pkg::*;
#(
  parameter int                AW          = ROM_AW,
  parameter int                MEM_AW      = 18,
  parameter logic [MEM_AW-1:0] BASE_ADDR   = '0,
  parameter bit                PREFETCH_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [AW-1:0]             rom_addr,
  input  logic                      rom_cs,
  output logic [7:0]                rom_data,
  output logic                      rom_valid,
  input  logic                      flush,
  rom_fetch_bridge_if.master        mem
);

  state_e            state_reg, state_next;
  logic              req_reg, req_next;
  logic [MEM_AW-1:0] addr_reg, addr_next;
  logic [AW-1:0]     tag_reg, tag_next;
  logic              discard_reg, discard_next;
  logic [7:0]        rom_data_reg, rom_data_next;
  logic              rom_valid_reg, rom_valid_next;

  logic              hit;
  logic [7:0]        hit_data;
  logic              probe_hit;
  logic              fill_en;
  logic              ack_v;
  logic              miss;
  logic              tag_match;
  logic              redirect;
  logic [AW-1:0]     tag_succ;

  function automatic logic [MEM_AW-1:0] to_mem_addr(input logic [AW-1:0] a);
    return BASE_ADDR + MEM_AW'(a);
  endfunction

  rom_line_buf u_line_buf (
    .clk         (clk),
    .rst_b       (rst_b),
    .lookup_en   (rom_cs),
    .lookup_addr (rom_addr),
    .probe_addr  (tag_succ),
    .fill_en     (fill_en),
    .fill_tag    (tag_reg),
    .fill_data   (mem.mem_rdata),
    .inval_all   (flush),
    .hit         (hit),
    .hit_data    (hit_data),
    .probe_hit   (probe_hit)
  );

  assign tag_succ  = next_tag(tag_reg);
  assign ack_v     = req_reg & mem.mem_ack;
  assign miss      = rom_cs & ~hit;
  assign tag_match = rom_cs & (rom_addr == tag_reg);
  // The ROM side moved to an address that is neither buffered nor in flight.
  assign redirect  = miss & (rom_addr != tag_reg);

  always_comb begin
    state_next     = state_reg;
    req_next       = req_reg;
    addr_next      = addr_reg;
    tag_next       = tag_reg;
    discard_next   = discard_reg;
    fill_en        = 1'b0;
    rom_valid_next = hit;
    rom_data_next  = hit ? hit_data : rom_data_reg;

    case (state_reg)
      IDLE: begin
        if (miss) begin
          state_next   = DEMAND;
          req_next     = 1'b1;
          addr_next    = to_mem_addr(rom_addr);
          tag_next     = rom_addr;
          discard_next = 1'b0;
        end
      end

      DEMAND, PREFETCH: begin
        if (!req_reg) begin
          // Prefetch issue slot, one clk after the demand request dropped.
          if (flush || redirect) begin
            state_next = IDLE;
          end else begin
            req_next  = 1'b1;
            addr_next = to_mem_addr(tag_reg);
          end
        end else if (ack_v) begin
          req_next = 1'b0;
          if (flush || discard_reg) begin
            state_next   = IDLE;
            discard_next = 1'b0;
          end else begin
            fill_en = 1'b1;
            // Covers both the demand return and a promoted prefetch.
            if (tag_match) begin
              rom_valid_next = 1'b1;
              rom_data_next  = mem.mem_rdata;
            end
            if ((state_reg == DEMAND) && PREFETCH_EN && !probe_hit && !redirect) begin
              state_next = PREFETCH;
              tag_next   = tag_succ;
            end else begin
              state_next = IDLE;
            end
          end
        end else if (flush) begin
          discard_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase

    if (flush) begin
      rom_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg     <= IDLE;
      req_reg       <= 1'b0;
      addr_reg      <= '0;
      tag_reg       <= '0;
      discard_reg   <= 1'b0;
      rom_data_reg  <= 8'h00;
      rom_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_reg       <= req_next;
      addr_reg      <= addr_next;
      tag_reg       <= tag_next;
      discard_reg   <= discard_next;
      rom_data_reg  <= rom_data_next;
      rom_valid_reg <= rom_valid_next;
    end
  end

  assign mem.mem_req  = req_reg;
  assign mem.mem_addr = addr_reg;
  assign rom_data     = rom_data_reg;
  assign rom_valid    = rom_valid_reg;

endmodule

// File: tb/tb_rom_fetch_bridge.sv
// Directed bench for rom_fetch_bridge: two instances (BASE_ADDR 0 and 0x4000)
// share ROM-side stimulus and memory acknowledgements.
module tb_rom_fetch_bridge;

  localparam logic [17:0] B1 = 18'h04000;

  logic        clk;
  logic        rst_b;
  logic [13:0] rom_addr;
  logic        rom_cs;
  logic        flush;
  logic [7:0]  rom_data0, rom_data1;
  logic        rom_valid0, rom_valid1;

  int total = 0;
  int bad   = 0;

  rom_fetch_bridge_if #(.MEM_AW(18)) m0 ();
  rom_fetch_bridge_if #(.MEM_AW(18)) m1 ();

  rom_fetch_bridge #(.AW(14), .MEM_AW(18), .BASE_ADDR(18'h00000), .PREFETCH_EN(1'b1)) dut0 (
    .clk(clk), .rst_b(rst_b), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_data(rom_data0), .rom_valid(rom_valid0), .flush(flush), .mem(m0)
  );

  rom_fetch_bridge #(.AW(14), .MEM_AW(18), .BASE_ADDR(18'h04000), .PREFETCH_EN(1'b1)) dut1 (
    .clk(clk), .rst_b(rst_b), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_data(rom_data1), .rom_valid(rom_valid1), .flush(flush), .mem(m1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for a request, checks its address on both instances and
  // that it is held, then acks after lat clks with data d.
  task automatic serve(input int lat, input logic [7:0] d, input logic [17:0] exp0,
                       input bit do_flush, input string nm);
    int n = 0;
    while (m0.mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (m0.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL %s req_seen: mem_req=%b required 1", nm, m0.mem_req);
    end
    total++;
    if (m0.mem_addr !== exp0 || m1.mem_addr !== exp0 + B1) begin
      bad++;
      $display("FAIL %s mem_addr: got %h/%h required %h/%h", nm, m0.mem_addr, m1.mem_addr, exp0, exp0 + B1);
    end
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      total++;
      if (m0.mem_req !== 1'b1 || m0.mem_addr !== exp0) begin
        bad++;
        $display("FAIL %s hold: req=%b addr=%h required 1/%h", nm, m0.mem_req, m0.mem_addr, exp0);
      end
    end
    m0.mem_ack = 1'b1; m1.mem_ack = 1'b1;
    m0.mem_rdata = d;  m1.mem_rdata = d;
    flush = do_flush;
    @(negedge clk);
    m0.mem_ack = 1'b0; m1.mem_ack = 1'b0;
    flush = 1'b0;
    total++;
    if (m0.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL %s req_drop: mem_req=%b required 0", nm, m0.mem_req);
    end
    $display("txn %s: addr=%h data=%h flush=%0d valid=%b rom_data=%h", nm, exp0, d, do_flush, rom_valid0, rom_data0);
  endtask

  task automatic test_reset();
    rst_b = 1'b0; rom_cs = 1'b0; rom_addr = '0; flush = 1'b0;
    m0.mem_ack = 1'b0; m1.mem_ack = 1'b0; m0.mem_rdata = '0; m1.mem_rdata = '0;
    repeat (2) @(negedge clk);
    total++;
    if (rom_data0 !== 8'h00) begin bad++; $display("FAIL reset_data: got %h required 00", rom_data0); end
    total++;
    if (rom_valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", rom_valid0); end
    total++;
    if (m0.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b required 0", m0.mem_req); end
    total++;
    if (m0.mem_addr !== 18'h0) begin bad++; $display("FAIL reset_addr: got %h required 00000", m0.mem_addr); end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    rom_cs = 1'b1; rom_addr = 14'h0100;
    serve(3, 8'hA9, 18'h00100, 1'b0, "cold_demand");
    total++;
    if (rom_valid0 !== 1'b1 || rom_data0 !== 8'hA9) begin
      bad++; $display("FAIL cold_data: got %b/%h required 1/a9", rom_valid0, rom_data0);
    end
    serve(2, 8'h01, 18'h00101, 1'b0, "cold_prefetch");
    total++;
    if (rom_valid0 !== 1'b1 || rom_data0 !== 8'hA9) begin
      bad++; $display("FAIL cold_keep: got %b/%h required 1/a9", rom_valid0, rom_data0);
    end
  endtask

  task automatic test_seq_hit();
    rom_addr = 14'h0101;
    @(negedge clk);
    total++;
    if (rom_valid0 !== 1'b1 || rom_data0 !== 8'h01) begin
      bad++; $display("FAIL seq_hit: got %b/%h required 1/01", rom_valid0, rom_data0);
    end
    rom_addr = 14'h0100;
    @(negedge clk);
    total++;
    if (rom_valid0 !== 1'b1 || rom_data0 !== 8'hA9) begin
      bad++; $display("FAIL seq_back: got %b/%h required 1/a9", rom_valid0, rom_data0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (m0.mem_req !== 1'b0) begin bad++; $display("FAIL seq_noreq: mem_req=%b required 0", m0.mem_req); end
    end
    $display("txn seq_hit: rom_data=%h valid=%b", rom_data0, rom_valid0);
  endtask

  task automatic test_wrap();
    rom_addr = 14'h3FFF;
    serve(1, 8'h3C, 18'h03FFF, 1'b0, "wrap_demand");
    total++;
    if (rom_valid1 !== 1'b1 || rom_data1 !== 8'h3C || rom_data0 !== 8'h3C) begin
      bad++; $display("FAIL wrap_data: got %b/%h/%h required 1/3c/3c", rom_valid1, rom_data1, rom_data0);
    end
    serve(1, 8'h5E, 18'h00000, 1'b0, "wrap_prefetch");
    rom_addr = 14'h0000;
    @(negedge clk);
    total++;
    if (rom_valid1 !== 1'b1 || rom_data1 !== 8'h5E) begin
      bad++; $display("FAIL wrap_hit: got %b/%h required 1/5e", rom_valid1, rom_data1);
    end
  endtask

  task automatic test_addr_change();
    rom_addr = 14'h0200;
    @(negedge clk);
    total++;
    if (m0.mem_req !== 1'b1 || m0.mem_addr !== 18'h00200) begin
      bad++; $display("FAIL chg_issue: got %b/%h required 1/00200", m0.mem_req, m0.mem_addr);
    end
    rom_addr = 14'h0300;
    @(negedge clk);
    total++;
    if (m0.mem_req !== 1'b1 || m0.mem_addr !== 18'h00200) begin
      bad++; $display("FAIL chg_hold: got %b/%h required 1/00200", m0.mem_req, m0.mem_addr);
    end
    m0.mem_ack = 1'b1; m1.mem_ack = 1'b1; m0.mem_rdata = 8'h77; m1.mem_rdata = 8'h77;
    @(negedge clk);
    m0.mem_ack = 1'b0; m1.mem_ack = 1'b0;
    total++;
    if (rom_valid0 !== 1'b0 || m0.mem_req !== 1'b0) begin
      bad++; $display("FAIL chg_stale: valid=%b req=%b required 0/0", rom_valid0, m0.mem_req);
    end
    $display("txn chg_old: addr=00200 data=77 valid=%b", rom_valid0);
    serve(2, 8'h88, 18'h00300, 1'b0, "chg_demand");
    total++;
    if (rom_valid0 !== 1'b1 || rom_data0 !== 8'h88) begin
      bad++; $display("FAIL chg_data: got %b/%h required 1/88", rom_valid0, rom_data0);
    end
    serve(1, 8'h99, 18'h00301, 1'b0, "chg_prefetch");
    rom_addr = 14'h0301;
    @(negedge clk);
    total++;
    if (rom_valid0 !== 1'b1 || rom_data0 !== 8'h99) begin
      bad++; $display("FAIL chg_pf_hit: got %b/%h required 1/99", rom_valid0, rom_data0);
    end
  endtask

  task automatic test_flush();
    rom_addr = 14'h0400;
    serve(2, 8'h55, 18'h00400, 1'b1, "flush_ack");
    total++;
    if (rom_valid0 !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b required 0", rom_valid0); end
    serve(1, 8'h56, 18'h00400, 1'b0, "flush_reissue");
    total++;
    if (rom_valid0 !== 1'b1 || rom_data0 !== 8'h56) begin
      bad++; $display("FAIL flush_refill: got %b/%h required 1/56", rom_valid0, rom_data0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    total++;
    if (m0.mem_req !== 1'b1 || m0.mem_addr !== 18'h00401 || rom_valid0 !== 1'b1) begin
      bad++; $display("FAIL rst_pre: got %b/%h/%b required 1/00401/1", m0.mem_req, m0.mem_addr, rom_valid0);
    end
    #2 rst_b = 1'b0;
    #1;
    total++;
    if (m0.mem_req !== 1'b0 || rom_valid0 !== 1'b0 || rom_data0 !== 8'h00 || m0.mem_addr !== 18'h0) begin
      bad++; $display("FAIL rst_async: got %b/%b/%h/%h required 0/0/00/00000", m0.mem_req, rom_valid0, rom_data0, m0.mem_addr);
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    total++;
    if (m0.mem_req !== 1'b1 || m0.mem_addr !== 18'h00400 || rom_valid0 !== 1'b0) begin
      bad++; $display("FAIL rst_miss: got %b/%h/%b required 1/00400/0", m0.mem_req, m0.mem_addr, rom_valid0);
    end
    serve(1, 8'h42, 18'h00400, 1'b0, "rst_refill");
    total++;
    if (rom_valid0 !== 1'b1 || rom_data0 !== 8'h42) begin
      bad++; $display("FAIL rst_data: got %b/%h required 1/42", rom_valid0, rom_data0);
    end
    serve(1, 8'h43, 18'h00401, 1'b0, "rst_prefetch");
  endtask

  task automatic test_flush_idle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (rom_valid0 !== 1'b0 || m0.mem_req !== 1'b0) begin
      bad++; $display("FAIL fidle_clear: got %b/%b required 0/0", rom_valid0, m0.mem_req);
    end
    @(negedge clk);
    total++;
    if (m0.mem_req !== 1'b1 || m0.mem_addr !== 18'h00400) begin
      bad++; $display("FAIL fidle_reissue: got %b/%h required 1/00400", m0.mem_req, m0.mem_addr);
    end
    serve(1, 8'h44, 18'h00400, 1'b0, "fidle_refill");
    serve(1, 8'h45, 18'h00401, 1'b0, "fidle_prefetch");
    total++;
    if (rom_valid0 !== 1'b1 || rom_data0 !== 8'h44) begin
      bad++; $display("FAIL fidle_data: got %b/%h required 1/44", rom_valid0, rom_data0);
    end
  endtask

  task automatic test_stray_ack();
    m0.mem_ack = 1'b1; m1.mem_ack = 1'b1; m0.mem_rdata = 8'hEE; m1.mem_rdata = 8'hEE;
    @(negedge clk);
    m0.mem_ack = 1'b0; m1.mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (rom_valid0 !== 1'b1 || rom_data0 !== 8'h44 || m0.mem_req !== 1'b0) begin
      bad++; $display("FAIL stray_ack: got %b/%h/%b required 1/44/0", rom_valid0, rom_data0, m0.mem_req);
    end
    $display("txn stray_ack: rom_data=%h valid=%b", rom_data0, rom_valid0);
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_seq_hit();
    test_wrap();
    test_addr_change();
    test_flush();
    test_reset_mid();
    test_flush_idle();
    test_stray_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
